// File: rtl/chimera_apb_cluster_ctrl.sv
// chimera_apb_cluster_ctrl
// APB completer for the TopLevelCfgRegs slot. For each external cluster it
// drives a clock enable, a timed soft-reset pulse and an isolation
// request/acknowledge handshake.
//
// Register offsets (paddr_i[7:0]):
//   0x00 CLK_EN   RW   per-cluster clock enable
//   0x04 RST      W1S  starts a RstCycles-long reset pulse; reads cluster_rst_o
//   0x08 ISO_TGT  RW   target isolation state per cluster
//   0x0C ISO_STAT RO   [i] isolated, [16+i] transition in progress
//   0x10 TIMEOUT  W1C  sticky handshake-timeout flags (optional build only)
//
// Optional build: define CHIMERA_CLU_CTRL_TIMEOUT_EN to abort isolation
// handshakes that get no acknowledge within TimeoutCycles cycles. Without
// that macro the FSMs wait indefinitely and 0x10 is unmapped.
module chimera_apb_cluster_ctrl #(
  parameter int unsigned NumClusters   = 5,
  parameter int unsigned AddrWidth     = 48,
  parameter int unsigned RstCycles     = 8,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   psel_i,
  input  logic                   penable_i,
  input  logic                   pwrite_i,
  input  logic [AddrWidth-1:0]   paddr_i,
  input  logic [31:0]            pwdata_i,
  input  logic [3:0]             pstrb_i,
  output logic [31:0]            prdata_o,
  output logic                   pready_o,
  output logic                   pslverr_o,
  output logic [NumClusters-1:0] cluster_clk_en_o,
  output logic [NumClusters-1:0] cluster_rst_o,
  output logic [NumClusters-1:0] cluster_iso_req_o,
  input  logic [NumClusters-1:0] cluster_iso_ack_i
);

  // Elaboration-time parameter sanity checks.
  if (NumClusters < 1 || NumClusters > 16) begin : g_bad_num_clusters
    $error("NumClusters must be in 1..16");
  end
  if (RstCycles < 1) begin : g_bad_rst_cycles
    $error("RstCycles must be at least 1");
  end
  if (TimeoutCycles < 1) begin : g_bad_timeout_cycles
    $error("TimeoutCycles must be at least 1");
  end
  if (AddrWidth < 9) begin : g_bad_addr_width
    $error("AddrWidth must be at least 9");
  end

  localparam int unsigned RstCntW = $clog2(RstCycles + 1);

  localparam logic [7:0] OffClkEn   = 8'h00;
  localparam logic [7:0] OffRst     = 8'h04;
  localparam logic [7:0] OffIsoTgt  = 8'h08;
  localparam logic [7:0] OffIsoStat = 8'h0C;
`ifdef CHIMERA_CLU_CTRL_TIMEOUT_EN
  localparam logic [7:0] OffTimeout = 8'h10;
  localparam int unsigned ToCntW = $clog2(TimeoutCycles + 1);
  localparam logic [ToCntW-1:0] ToLast = ToCntW'(TimeoutCycles - 1);
`endif

  typedef enum logic [1:0] {
    ST_ACTIVE    = 2'd0,
    ST_ISOLATING = 2'd1,
    ST_ISOLATED  = 2'd2,
    ST_RELEASING = 2'd3
  } iso_state_e;

  // APB response registers
  logic        pready_q;
  logic        pslverr_q;
  logic [31:0] prdata_q;

  // Configuration and per-cluster state
  logic [NumClusters-1:0] clk_en_q, clk_en_d;
  logic [NumClusters-1:0] iso_tgt_q, iso_tgt_wr;
  logic [NumClusters-1:0] iso_req_q;
  logic [RstCntW-1:0]     rst_cnt_q [NumClusters];
  logic [RstCntW-1:0]     rst_cnt_d [NumClusters];
  iso_state_e             state_q   [NumClusters];
`ifdef CHIMERA_CLU_CTRL_TIMEOUT_EN
  logic [ToCntW-1:0]      to_cnt_q  [NumClusters];
  logic [NumClusters-1:0] to_stat_q;
`endif

  // Bus decode
  logic [7:0]             offs;
  logic                   access_first;
  logic                   commit_wr;
  logic [15:0]            wmask16;
  logic [15:0]            wdata16;
  logic [NumClusters-1:0] wmask_n;
  logic [NumClusters-1:0] wdata_n;
  logic                   wr_clk_en, wr_rst, wr_iso_tgt;
  logic [NumClusters-1:0] stat_iso, stat_busy;
  logic [31:0]            rd_data;
  logic                   rd_err;
  logic                   unused_bits;

  // The wait state is the first enable cycle; the second one is the ready
  // cycle, at whose closing edge a write takes effect.
  assign offs         = paddr_i[7:0];
  assign access_first = psel_i & penable_i & ~pready_q;
  assign commit_wr    = psel_i & penable_i & pready_q & pwrite_i;

  // Only the two low bytes carry cluster bits; strobes mask them per byte.
  assign wmask16 = {{8{pstrb_i[1]}}, {8{pstrb_i[0]}}};
  assign wdata16 = pwdata_i[15:0] & wmask16;
  assign wmask_n = wmask16[NumClusters-1:0];
  assign wdata_n = wdata16[NumClusters-1:0];

  assign wr_clk_en  = commit_wr && (offs == OffClkEn);
  assign wr_rst     = commit_wr && (offs == OffRst);
  assign wr_iso_tgt = commit_wr && (offs == OffIsoTgt);

  assign iso_tgt_wr = (iso_tgt_q & ~wmask_n) | (wdata_n & wmask_n);

  assign unused_bits = ^{paddr_i[AddrWidth-1:8], pwdata_i[31:16], pstrb_i[3:2],
                         wdata16, wmask16};

  // Status decode of each cluster FSM and reset-pulse outputs.
  always_comb begin
    stat_iso      = '0;
    stat_busy     = '0;
    cluster_rst_o = '0;
    for (int i = 0; i < NumClusters; i++) begin
      stat_iso[i]      = (state_q[i] == ST_ISOLATED);
      stat_busy[i]     = (state_q[i] == ST_ISOLATING) || (state_q[i] == ST_RELEASING);
      cluster_rst_o[i] = (rst_cnt_q[i] != '0);
    end
  end

  // Read mux and error decode for the access presented on the bus.
  always_comb begin
    rd_data = '0;
    rd_err  = 1'b0;
    case (offs)
      OffClkEn:   rd_data[NumClusters-1:0] = clk_en_q;
      OffRst:     rd_data[NumClusters-1:0] = cluster_rst_o;
      OffIsoTgt:  rd_data[NumClusters-1:0] = iso_tgt_q;
      OffIsoStat: begin
        rd_data[NumClusters-1:0]    = stat_iso;
        rd_data[16 +: NumClusters]  = stat_busy;
        rd_err                      = pwrite_i;
      end
`ifdef CHIMERA_CLU_CTRL_TIMEOUT_EN
      OffTimeout: rd_data[NumClusters-1:0] = to_stat_q;
`endif
      default:    rd_err = 1'b1;
    endcase
  end

  // APB response: one wait state, then a single ready cycle carrying data/error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else if (access_first) begin
      pready_q  <= 1'b1;
      pslverr_q <= rd_err;
      prdata_q  <= pwrite_i ? 32'h0 : rd_data;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end
  end

  // Next clock-enable and reset-pulse counter values.
  always_comb begin
    clk_en_d = clk_en_q;
    if (wr_clk_en) clk_en_d = (clk_en_q & ~wmask_n) | (wdata_n & wmask_n);
    for (int i = 0; i < NumClusters; i++) begin
      rst_cnt_d[i] = rst_cnt_q[i];
      if (wr_rst && wdata_n[i]) begin
        // A write during a pulse reloads and so extends it.
        rst_cnt_d[i] = RstCntW'(RstCycles);
      end else if (rst_cnt_q[i] != '0) begin
        rst_cnt_d[i] = rst_cnt_q[i] - 1'b1;
      end
    end
  end

  // Clock-enable register and soft-reset counters.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      clk_en_q <= '0;
      for (int i = 0; i < NumClusters; i++) rst_cnt_q[i] <= '0;
    end else begin
      clk_en_q <= clk_en_d;
      for (int i = 0; i < NumClusters; i++) rst_cnt_q[i] <= rst_cnt_d[i];
    end
  end

  // Isolation FSMs; the target is only sampled in the stable states so a
  // target flipped mid-handshake is acted on once the handshake completes.
  // A timeout abort overrides a same-cycle bus write to the target bit, and a
  // timeout flag set overrides a same-cycle clear.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      iso_tgt_q <= '0;
      iso_req_q <= '0;
      for (int i = 0; i < NumClusters; i++) state_q[i] <= ST_ACTIVE;
`ifdef CHIMERA_CLU_CTRL_TIMEOUT_EN
      to_stat_q <= '0;
      for (int i = 0; i < NumClusters; i++) to_cnt_q[i] <= '0;
`endif
    end else begin
      if (wr_iso_tgt) iso_tgt_q <= iso_tgt_wr;
`ifdef CHIMERA_CLU_CTRL_TIMEOUT_EN
      if (commit_wr && (offs == OffTimeout)) to_stat_q <= to_stat_q & ~wdata_n;
`endif
      for (int i = 0; i < NumClusters; i++) begin
`ifdef CHIMERA_CLU_CTRL_TIMEOUT_EN
        to_cnt_q[i] <= '0;
`endif
        case (state_q[i])
          ST_ACTIVE: begin
            if (iso_tgt_q[i]) begin
              state_q[i]   <= ST_ISOLATING;
              iso_req_q[i] <= 1'b1;
            end
          end
          ST_ISOLATING: begin
            if (cluster_iso_ack_i[i]) begin
              state_q[i] <= ST_ISOLATED;
            end
`ifdef CHIMERA_CLU_CTRL_TIMEOUT_EN
            else if (to_cnt_q[i] == ToLast) begin
              state_q[i]   <= ST_ACTIVE;
              iso_req_q[i] <= 1'b0;
              iso_tgt_q[i] <= 1'b0;
              to_stat_q[i] <= 1'b1;
            end else begin
              to_cnt_q[i] <= to_cnt_q[i] + 1'b1;
            end
`endif
          end
          ST_ISOLATED: begin
            if (!iso_tgt_q[i]) begin
              state_q[i]   <= ST_RELEASING;
              iso_req_q[i] <= 1'b0;
            end
          end
          ST_RELEASING: begin
            if (!cluster_iso_ack_i[i]) begin
              state_q[i] <= ST_ACTIVE;
            end
`ifdef CHIMERA_CLU_CTRL_TIMEOUT_EN
            else if (to_cnt_q[i] == ToLast) begin
              state_q[i]   <= ST_ISOLATED;
              iso_req_q[i] <= 1'b1;
              iso_tgt_q[i] <= 1'b1;
              to_stat_q[i] <= 1'b1;
            end else begin
              to_cnt_q[i] <= to_cnt_q[i] + 1'b1;
            end
`endif
          end
          default: begin
            state_q[i]   <= ST_ACTIVE;
            iso_req_q[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  assign prdata_o          = prdata_q;
  assign pready_o          = pready_q;
  assign pslverr_o         = pslverr_q;
  assign cluster_clk_en_o  = clk_en_q;
  assign cluster_iso_req_o = iso_req_q;

endmodule

// File: tb/tb_chimera_apb_cluster_ctrl.sv
// Directed testbench for chimera_apb_cluster_ctrl (NumClusters=5, RstCycles=8,
// TimeoutCycles=16). Define CHIMERA_CLU_CTRL_TIMEOUT_EN to cover the
// handshake-timeout build.
module tb_chimera_apb_cluster_ctrl;

  localparam int unsigned N = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        psel, penable, pwrite;
  logic [47:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [N-1:0] clk_en, rst_o, iso_req, iso_ack;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  chimera_apb_cluster_ctrl #(
    .NumClusters  (N),
    .AddrWidth    (48),
    .RstCycles    (8),
    .TimeoutCycles(16)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .psel_i           (psel),
    .penable_i        (penable),
    .pwrite_i         (pwrite),
    .paddr_i          (paddr),
    .pwdata_i         (pwdata),
    .pstrb_i          (pstrb),
    .prdata_o         (prdata),
    .pready_o         (pready),
    .pslverr_o        (pslverr),
    .cluster_clk_en_o (clk_en),
    .cluster_rst_o    (rst_o),
    .cluster_iso_req_o(iso_req),
    .cluster_iso_ack_i(iso_ack)
  );

  // One APB transfer: setup, wait-state, ready. Returns one step after the
  // edge that closes the ready cycle.
  task automatic apb_xfer(input logic wr, input logic [7:0] a, input logic [31:0] wd,
                          input logic [3:0] sb, output logic [31:0] rd,
                          output logic err, output logic rdy1, output logic rdy2);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr;
    paddr = {40'hAB_CDEF_0123, a}; pwdata = wd; pstrb = sb;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk); rdy1 = pready;
    @(posedge clk);
    @(negedge clk); rdy2 = pready; rd = prdata; err = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pstrb = 4'h0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if ({prdata, pready, pslverr, clk_en, rst_o, iso_req} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got prdata=%h rdy=%b err=%b clk_en=%b rst=%b req=%b want all 0",
               prdata, pready, pslverr, clk_en, rst_o, iso_req);
    end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_clk_en();
    logic [31:0] rd; logic err, r1, r2;
    apb_xfer(1'b1, 8'h00, 32'h0000_0015, 4'hF, rd, err, r1, r2);
    n_vec++;
    if ({r1, r2, err} !== 3'b010) begin
      n_err++; $display("FAIL clk_en_wr_timing: got rdy1/rdy2/err=%b%b%b want 010", r1, r2, err);
    end
    n_vec++;
    if (rd !== 32'h0) begin
      n_err++; $display("FAIL clk_en_wr_prdata: got %h want 0", rd);
    end
    @(negedge clk);
    n_vec++;
    if (pready !== 1'b0) begin
      n_err++; $display("FAIL pready_drop: got %b want 0", pready);
    end
    n_vec++;
    if (clk_en !== 5'b10101) begin
      n_err++; $display("FAIL clk_en_out: got %b want 10101", clk_en);
    end
    apb_xfer(1'b0, 8'h00, 32'h0, 4'h0, rd, err, r1, r2);
    n_vec++;
    if ({rd, r1, r2, err} !== {32'h15, 3'b010}) begin
      n_err++; $display("FAIL clk_en_rd: got data=%h rdy1/rdy2/err=%b%b%b want 15 010", rd, r1, r2, err);
    end
    // Zero strobes: no effect, no error.
    apb_xfer(1'b1, 8'h00, 32'h0, 4'h0, rd, err, r1, r2);
    n_vec++;
    if ({clk_en, err} !== {5'b10101, 1'b0}) begin
      n_err++; $display("FAIL strb_zero: got clk_en=%b err=%b want 10101 0", clk_en, err);
    end
    // Byte-0 strobe with all ones: bits above N are dropped.
    apb_xfer(1'b1, 8'h00, 32'hFFFF_FFFF, 4'b0001, rd, err, r1, r2);
    apb_xfer(1'b0, 8'h00, 32'h0, 4'h0, rd, err, r1, r2);
    n_vec++;
    if ({rd, clk_en} !== {32'h1F, 5'h1F}) begin
      n_err++; $display("FAIL strb_byte0: got rd=%h clk_en=%b want 1f 11111", rd, clk_en);
    end
    // Byte-1 strobe only: no cluster bits live there.
    apb_xfer(1'b1, 8'h00, 32'h0, 4'b0010, rd, err, r1, r2);
    n_vec++;
    if (clk_en !== 5'h1F) begin
      n_err++; $display("FAIL strb_byte1: got clk_en=%b want 11111", clk_en);
    end
    apb_xfer(1'b1, 8'h00, 32'h0, 4'hF, rd, err, r1, r2);
  endtask

  task automatic test_soft_rst();
    logic [31:0] rd; logic err, r1, r2;
    int hi, edges; logic prev;
    // Single pulse: count high cycles of bit 1 over a window covering the write.
    hi = 0; edges = 0; prev = 1'b0;
    fork
      begin
        apb_xfer(1'b1, 8'h04, 32'h2, 4'hF, rd, err, r1, r2);
        @(negedge clk);
        n_vec++;
        if (rst_o !== 5'b00010) begin
          n_err++; $display("FAIL rst_first_cycle: got %b want 00010", rst_o);
        end
      end
      for (int k = 0; k < 30; k++) begin
        @(negedge clk);
        if (rst_o[1]) hi++;
        if (rst_o[1] && !prev) edges++;
        prev = rst_o[1];
      end
    join
    n_vec++;
    if ({hi, edges} !== {32'd8, 32'd1}) begin
      n_err++; $display("FAIL rst_pulse_len: got %0d cycles %0d pulses want 8 cycles 1 pulse", hi, edges);
    end
    // Re-write whose commit closes pulse cycle 5: 5 + 8 = 13.
    hi = 0; edges = 0; prev = 1'b0;
    fork
      begin
        apb_xfer(1'b1, 8'h04, 32'h2, 4'hF, rd, err, r1, r2);
        @(posedge clk);
        apb_xfer(1'b1, 8'h04, 32'h2, 4'hF, rd, err, r1, r2);
      end
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (rst_o[1]) hi++;
        if (rst_o[1] && !prev) edges++;
        prev = rst_o[1];
      end
    join
    n_vec++;
    if ({hi, edges} !== {32'd13, 32'd1}) begin
      n_err++; $display("FAIL rst_extend: got %0d cycles %0d pulses want 13 cycles 1 pulse", hi, edges);
    end
    // Two clusters at once, and RST reads back the live pulse.
    apb_xfer(1'b1, 8'h04, 32'h11, 4'hF, rd, err, r1, r2);
    @(negedge clk);
    n_vec++;
    if (rst_o !== 5'b10001) begin
      n_err++; $display("FAIL rst_multi: got %b want 10001", rst_o);
    end
    apb_xfer(1'b0, 8'h04, 32'h0, 4'h0, rd, err, r1, r2);
    n_vec++;
    if (rd !== 32'h11) begin
      n_err++; $display("FAIL rst_readback: got %h want 11", rd);
    end
    repeat (10) @(posedge clk);
    apb_xfer(1'b0, 8'h04, 32'h0, 4'h0, rd, err, r1, r2);
    n_vec++;
    if ({rd, rst_o} !== {32'h0, 5'b0}) begin
      n_err++; $display("FAIL rst_idle: got rd=%h rst=%b want 0 0", rd, rst_o);
    end
  endtask

  task automatic test_isolation();
    logic [31:0] rd; logic err, r1, r2;
    apb_xfer(1'b1, 8'h08, 32'h1, 4'hF, rd, err, r1, r2);
    @(posedge clk); @(negedge clk);
    n_vec++;
    if (iso_req !== 5'b00001) begin
      n_err++; $display("FAIL iso_req_rise: got %b want 00001", iso_req);
    end
    apb_xfer(1'b0, 8'h0C, 32'h0, 4'h0, rd, err, r1, r2);
    n_vec++;
    if ({rd, err} !== {32'h0001_0000, 1'b0}) begin
      n_err++; $display("FAIL iso_stat_isolating: got %h err=%b want 00010000 0", rd, err);
    end
    apb_xfer(1'b0, 8'h08, 32'h0, 4'h0, rd, err, r1, r2);
    n_vec++;
    if (rd !== 32'h1) begin
      n_err++; $display("FAIL iso_tgt_rd: got %h want 1", rd);
    end
    iso_ack[0] = 1'b1;
    repeat (2) @(posedge clk);
    apb_xfer(1'b0, 8'h0C, 32'h0, 4'h0, rd, err, r1, r2);
    n_vec++;
    if ({rd, iso_req} !== {32'h1, 5'b00001}) begin
      n_err++; $display("FAIL iso_isolated: got stat=%h req=%b want 1 00001", rd, iso_req);
    end
    // Release, then flip target back during RELEASING.
    apb_xfer(1'b1, 8'h08, 32'h0, 4'hF, rd, err, r1, r2);
    @(posedge clk); @(negedge clk);
    n_vec++;
    if (iso_req !== 5'b0) begin
      n_err++; $display("FAIL iso_req_fall: got %b want 00000", iso_req);
    end
    apb_xfer(1'b1, 8'h08, 32'h1, 4'hF, rd, err, r1, r2);
    apb_xfer(1'b0, 8'h0C, 32'h0, 4'h0, rd, err, r1, r2);
    n_vec++;
    if ({rd, iso_req} !== {32'h0001_0000, 5'b0}) begin
      n_err++; $display("FAIL iso_releasing_hold: got stat=%h req=%b want 00010000 00000", rd, iso_req);
    end
    iso_ack[0] = 1'b0;
    repeat (3) @(posedge clk);
    apb_xfer(1'b0, 8'h0C, 32'h0, 4'h0, rd, err, r1, r2);
    n_vec++;
    if ({rd, iso_req} !== {32'h0001_0000, 5'b00001}) begin
      n_err++; $display("FAIL iso_reisolate: got stat=%h req=%b want 00010000 00001", rd, iso_req);
    end
    iso_ack[0] = 1'b1;
    repeat (2) @(posedge clk);
    apb_xfer(1'b1, 8'h08, 32'h0, 4'hF, rd, err, r1, r2);
    repeat (2) @(posedge clk);
    iso_ack[0] = 1'b0;
    repeat (3) @(posedge clk);
    apb_xfer(1'b0, 8'h0C, 32'h0, 4'h0, rd, err, r1, r2);
    n_vec++;
    if ({rd, iso_req} !== {32'h0, 5'b0}) begin
      n_err++; $display("FAIL iso_released: got stat=%h req=%b want 0 00000", rd, iso_req);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic err, r1, r2;
    apb_xfer(1'b1, 8'h00, 32'h0A, 4'hF, rd, err, r1, r2);
    apb_xfer(1'b0, 8'h20, 32'h0, 4'h0, rd, err, r1, r2);
    n_vec++;
    if ({rd, r2, err} !== {32'h0, 2'b11}) begin
      n_err++; $display("FAIL err_rd_unmapped: got data=%h rdy=%b err=%b want 0 1 1", rd, r2, err);
    end
    apb_xfer(1'b1, 8'h0C, 32'hFFFF_FFFF, 4'hF, rd, err, r1, r2);
    n_vec++;
    if ({rd, err} !== {32'h0, 1'b1}) begin
      n_err++; $display("FAIL err_wr_ro: got data=%h err=%b want 0 1", rd, err);
    end
    apb_xfer(1'b1, 8'h20, 32'h1F, 4'hF, rd, err, r1, r2);
    apb_xfer(1'b0, 8'h0C, 32'h0, 4'h0, rd, err, r1, r2);
    n_vec++;
    if ({rd, clk_en, iso_req} !== {32'h0, 5'h0A, 5'h0}) begin
      n_err++; $display("FAIL err_no_effect: got stat=%h clk_en=%b req=%b want 0 01010 00000", rd, clk_en, iso_req);
    end
`ifndef CHIMERA_CLU_CTRL_TIMEOUT_EN
    apb_xfer(1'b0, 8'h10, 32'h0, 4'h0, rd, err, r1, r2);
    n_vec++;
    if ({rd, err} !== {32'h0, 1'b1}) begin
      n_err++; $display("FAIL err_timeout_unmapped: got data=%h err=%b want 0 1", rd, err);
    end
`endif
  endtask

`ifdef CHIMERA_CLU_CTRL_TIMEOUT_EN
  task automatic test_timeout();
    logic [31:0] rd; logic err, r1, r2;
    iso_ack = '0;
    apb_xfer(1'b1, 8'h08, 32'h4, 4'hF, rd, err, r1, r2);
    repeat (8) @(posedge clk);
    apb_xfer(1'b0, 8'h0C, 32'h0, 4'h0, rd, err, r1, r2);
    n_vec++;
    if (rd !== 32'h0004_0000) begin
      n_err++; $display("FAIL to_waiting: got %h want 00040000", rd);
    end
    repeat (20) @(posedge clk);
    apb_xfer(1'b0, 8'h0C, 32'h0, 4'h0, rd, err, r1, r2);
    n_vec++;
    if ({rd, iso_req} !== {32'h0, 5'b0}) begin
      n_err++; $display("FAIL to_abort_state: got stat=%h req=%b want 0 00000", rd, iso_req);
    end
    apb_xfer(1'b0, 8'h08, 32'h0, 4'h0, rd, err, r1, r2);
    n_vec++;
    if (rd !== 32'h0) begin
      n_err++; $display("FAIL to_tgt_cleared: got %h want 0", rd);
    end
    apb_xfer(1'b0, 8'h10, 32'h0, 4'h0, rd, err, r1, r2);
    n_vec++;
    if ({rd, err} !== {32'h4, 1'b0}) begin
      n_err++; $display("FAIL to_sticky: got %h err=%b want 4 0", rd, err);
    end
    apb_xfer(1'b1, 8'h10, 32'h4, 4'hF, rd, err, r1, r2);
    apb_xfer(1'b0, 8'h10, 32'h0, 4'h0, rd, err, r1, r2);
    n_vec++;
    if (rd !== 32'h0) begin
      n_err++; $display("FAIL to_w1c: got %h want 0", rd);
    end
  endtask
`endif

  task automatic test_reset_mid();
    // Write to CLK_EN abandoned by reset during its ready cycle.
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 48'h0; pwdata = 32'h1F; pstrb = 4'hF;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({pready, clk_en, rst_o, iso_req} !== '0) begin
      n_err++; $display("FAIL reset_mid_xfer: got rdy=%b clk_en=%b rst=%b req=%b want all 0",
                        pready, clk_en, rst_o, iso_req);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (clk_en !== 5'b0) begin
      n_err++; $display("FAIL reset_no_commit: got clk_en=%b want 00000", clk_en);
    end
  endtask

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; iso_ack = '0;
    test_reset();
    test_clk_en();
    test_soft_rst();
    test_isolation();
    test_errors();
`ifdef CHIMERA_CLU_CTRL_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/chimera_apb_cluster_ctrl.md
Name: chimera_apb_cluster_ctrl

Overview:
APB completer sitting on the TopLevelCfgRegs slot of the external register bus. It answers CVA6-initiated APB reads and writes and, per external cluster, drives the clock enable, a timed soft-reset pulse and an isolation request/acknowledge handshake. It is the responder end of the SoC's APB configuration interface, feeding cluster power-management and isolation logic.

Parameters:
NumClusters, 5, number of external clusters controlled; legal range 1..16.
AddrWidth, 48, APB address width.
RstCycles, 8, length of the soft-reset pulse in clk_i cycles; minimum 1.
TimeoutCycles, 1024, isolation handshake timeout, used only with the optional feature.

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous, active-high reset
psel_i  in  1  APB select
penable_i  in  1  APB enable
pwrite_i  in  1  APB write
paddr_i  in  AddrWidth  APB address; only bits [7:0] are decoded
pwdata_i  in  32  APB write data
pstrb_i  in  4  APB byte strobes
prdata_o  out  32  APB read data
pready_o  out  1  APB ready
pslverr_o  out  1  APB error
cluster_clk_en_o  out  NumClusters  per-cluster clock enable
cluster_rst_o  out  NumClusters  per-cluster active-high soft reset
cluster_iso_req_o  out  NumClusters  isolation request
cluster_iso_ack_i  in  NumClusters  isolation acknowledge; level signal from the cluster

Behaviour:
- Reset: all outputs 0. All registers 0. All cluster FSMs in ACTIVE. All counters 0.
- APB timing:
  - Exactly one wait state. First access cycle (psel & penable & !pready_o): pready_o=0.
  - Next cycle: pready_o=1, prdata_o and pslverr_o valid, write committed.
  - pready_o returns to 0 the following cycle.
  - prdata_o is 0 outside the ready cycle and on writes.
- Byte strobes: pstrb_i applies per byte to RW registers. A write with pstrb_i=0 is a no-op with no error.
- Register map (offset = paddr_i[7:0]):
  - 0x00 CLK_EN, RW, bits [N-1:0]; drives cluster_clk_en_o directly.
  - 0x04 RST, write-1 starts a pulse; reads cluster_rst_o.
  - 0x08 ISO_TGT, RW; target isolation state per cluster.
  - 0x0C ISO_STAT, RO; bit i = FSM in ISOLATED, bit 16+i = FSM in ISOLATING or RELEASING.
  - Any other offset: pslverr_o=1, reads return 0, writes have no effect.
  - Writes to RO registers: pslverr_o=1, no effect.
  - Bits at or above NumClusters read 0 and ignore writes (status bits at or above 16+NumClusters likewise).
- Soft reset, per cluster:
  - Writing 1 to RST bit i loads counter i with RstCycles.
  - cluster_rst_o[i]=1 while counter != 0; counter decrements each cycle.
  - The first reset cycle is the cycle after the write commit; the pulse is exactly RstCycles cycles.
  - A re-write during a pulse reloads the counter, extending the pulse.
- Isolation FSM, per cluster:
  - ACTIVE: iso_req=0. Moves to ISOLATING when ISO_TGT[i]=1.
  - ISOLATING: iso_req=1. Moves to ISOLATED on ack=1.
  - ISOLATED: iso_req=1. Moves to RELEASING when ISO_TGT[i]=0.
  - RELEASING: iso_req=0. Moves to ACTIVE on ack=0.
  - ISO_TGT may change at any time. The FSM evaluates it only in stable states (ACTIVE or ISOLATED), so a target toggled back during a transition is honoured after the transition completes.
  - An ack already at the awaited level on entry completes the transition the next cycle.
  - The isolation FSMs, RST and CLK_EN are independent. Simultaneous events on different clusters or registers all take effect in the same cycle.
- Reset mid-transfer: an APB access is abandoned with no commit. All state returns to reset values the cycle after rst_i.

Optional Feature:
Macro CHIMERA_CLU_CTRL_TIMEOUT_EN.
- Defined:
  - Each cluster has a timeout counter that counts while in ISOLATING or RELEASING.
  - When the counter reaches TimeoutCycles without the awaited ack, the FSM aborts. ISOLATING returns to ACTIVE (ISO_TGT[i] cleared). RELEASING returns to ISOLATED (ISO_TGT[i] set).
  - On abort, sticky bit i of 0x10 TIMEOUT is set. 0x10 is W1C; write-1 clears.
  - On a same-cycle set and clear, set wins.
- Not defined: FSMs wait indefinitely for ack. 0x10 is unmapped (pslverr_o=1).

Test Plan:
1. APB write 0x00=0x15, then read 0x00 -> cluster_clk_en_o=5'b10101; read returns 0x15; pready_o high exactly on the 2nd access cycle; pslverr_o=0.
2. Write 0x04=0x2 -> cluster_rst_o[1] high for exactly 8 cycles starting the cycle after commit. A re-write at cycle 5 extends the pulse to 13 total cycles.
3. Write 0x08=0x1, then ack[0] rises 3 cycles later -> iso_req_o[0]=1. ISO_STAT reads 0x0001_0000 during the wait, 0x0000_0001 after ack.
4. Write 0x08=0x0, then ack[0] falls -> RELEASING, then ACTIVE. ISO_STAT=0. Toggling the target back to 1 during RELEASING yields a re-isolation after ACTIVE is reached.
5. Read 0x20 and write 0x0C -> pslverr_o=1, prdata_o=0, no state change.
6. With CHIMERA_CLU_CTRL_TIMEOUT_EN and TimeoutCycles=16: write 0x08=0x4 with ack held 0 -> after 16 cycles FSM2 is ACTIVE, ISO_TGT=0, TIMEOUT=0x4. Writing 0x10=0x4 clears it to 0.
